// File: rtl/add_round_key_sched.sv
// AddRoundKey stage with a word-serial AES-128 key schedule: XORs each accepted state with
// the current round key, then expands the next round key one 32-bit word per cycle.
module add_round_key_sched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        NOKEY = 3'd0,
        READY = 3'd1,
        EXP0  = 3'd2,
        EXP1  = 3'd3,
        EXP2  = 3'd4,
        EXP3  = 3'd5
    } state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t        state;
    state_t        state_next;
    logic [127:0]  base_key;
    logic [127:0]  rk;
    logic [3:0]    round;
    logic [7:0]    rcon;
    logic          accept;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // out_valid and its payload hold until out_ready; in_ready never depends on in_valid.
    always_comb begin
        in_ready = !rst && !key_load && (state == READY) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NOKEY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (key_load) begin
            state_next = READY;
        end else begin
            case (state)
                NOKEY:   state_next = NOKEY;
                READY:   if (accept && (round != NR_L)) state_next = EXP0;
                EXP0:    state_next = EXP1;
                EXP1:    state_next = EXP2;
                EXP2:    state_next = EXP3;
                EXP3:    state_next = READY;
                default: state_next = NOKEY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_key  <= '0;
            rk        <= '0;
            round     <= '0;
            rcon      <= 8'h01;
            out_valid <= 1'b0;
            data_out  <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else if (key_load) begin
            base_key  <= key_in;
            rk        <= key_in;
            round     <= '0;
            rcon      <= 8'h01;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                data_out  <= data_in ^ rk;
                out_round <= round;
                out_last  <= (round == NR_L);
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                READY: begin
                    if (accept) begin
                        // The final round rewinds to the cipher key with no expansion gap.
                        if (round == NR_L) begin
                            rk    <= base_key;
                            round <= '0;
                            rcon  <= 8'h01;
                        end else begin
                            round <= round + 4'd1;
                        end
                    end
                end
                EXP0: rk[127:96] <= rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rcon, 24'h0};
                EXP1: rk[95:64]  <= rk[95:64] ^ rk[127:96];
                EXP2: rk[63:32]  <= rk[63:32] ^ rk[95:64];
                EXP3: begin
                    rk[31:0] <= rk[31:0] ^ rk[63:32];
                    rcon     <= xtime(rcon);
                end
                default: ;
            endcase
        end
    end

endmodule
